mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/arb_starve_cnt.sv | 31 +++
 rtl/mem_arbiter.sv | 98 +++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side types: data widths, response-ownership states and the memory command payload.
package cpu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned BE_W    = 4;
  localparam int unsigned WORD_AW = XLEN - 2;

  // Which requester owns the memory response arriving next cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } own_t;

  // One memory access as driven toward the RAM in the accept cycle
  typedef struct packed {
    logic               en;
    logic               we;
    logic [BE_W-1:0]    be;
    logic [WORD_AW-1:0] addr;
    logic [XLEN-1:0]    wdata;
  } mem_cmd_t;

  // Byte address to word index; the low two bits select lanes and are dropped
  function automatic logic [WORD_AW-1:0] word_idx(input logic [XLEN-1:0] byte_addr);
    return byte_addr[XLEN-1:2];
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, load/store and memory-side signals of the single-port memory arbiter.
interface mem_arbiter_if;
  import cpu_pkg::*;

  logic               if_req_valid;
  logic [XLEN-1:0]    if_req_addr;
  logic               if_req_ready;
  logic               if_rsp_valid;
  logic [XLEN-1:0]    if_rsp_data;

  logic               ls_req_valid;
  logic               ls_req_we;
  logic [BE_W-1:0]    ls_req_be;
  logic [XLEN-1:0]    ls_req_addr;
  logic [XLEN-1:0]    ls_req_wdata;
  logic               ls_req_ready;
  logic               ls_rsp_valid;
  logic [XLEN-1:0]    ls_rsp_data;

  logic               mem_en;
  logic               mem_we;
  logic [BE_W-1:0]    mem_be;
  logic [WORD_AW-1:0] mem_addr;
  logic [XLEN-1:0]    mem_wdata;
  logic [XLEN-1:0]    mem_rdata;

  // Requesters and memory model side
  modport master (
    output if_req_valid, if_req_addr, ls_req_valid, ls_req_we, ls_req_be,
           ls_req_addr, ls_req_wdata, mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data, ls_req_ready, ls_rsp_valid,
           ls_rsp_data, mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  // Arbiter side
  modport slave (
    input  if_req_valid, if_req_addr, ls_req_valid, ls_req_we, ls_req_be,
           ls_req_addr, ls_req_wdata, mem_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_data, ls_req_ready, ls_rsp_valid,
           ls_rsp_data, mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/arb_starve_cnt.sv
// Fetch starvation counter; only present when MEM_ARB_FAIRNESS_EN is defined.
`ifdef MEM_ARB_FAIRNESS_EN
module arb_starve_cnt #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_valid,
  input  logic if_ready,
  output logic force_c
);

  localparam int unsigned CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  // Count consecutive refused fetch cycles, saturating; a fetch accept or an idle fetch restarts the run
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!if_valid || if_ready) begin
      cnt_q <= '0;
    end else if (cnt_q != CW'(LIMIT)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign force_c = (cnt_q == CW'(LIMIT));

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, load/store) arbiter in front of a single-port synchronous memory.
// Load/store wins by default; defining MEM_ARB_FAIRNESS_EN adds a starvation counter that
// forces one fetch through after STARVE_LIMIT consecutive refusals.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  own_t     own_q, own_d;
  logic     store_q, store_d;
  logic     grant_if_c, grant_ls_c;
  logic     fetch_first_c;
  mem_cmd_t cmd_c;

`ifdef MEM_ARB_FAIRNESS_EN
  arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk      (clk),
    .reset    (reset),
    .if_valid (bus.if_req_valid),
    .if_ready (grant_if_c),
    .force_c  (fetch_first_c)
  );
`else
  logic unused_limit;
  assign fetch_first_c = 1'b0;
  assign unused_limit  = ^STARVE_LIMIT;
`endif

  // Lane selection is the requester's job, so the byte offset is never looked at
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{bus.if_req_addr[1:0], bus.ls_req_addr[1:0]};

  // Response ownership register; reset drops any in-flight response
  always_ff @(posedge clk) begin
    if (reset) begin
      own_q   <= OWN_NONE;
      store_q <= 1'b0;
    end else begin
      own_q   <= own_d;
      store_q <= store_d;
    end
  end

  // Grant selection, memory command and next owner
  always_comb begin
    own_d      = OWN_NONE;
    store_d    = 1'b0;
    grant_if_c = 1'b0;
    grant_ls_c = 1'b0;
    cmd_c      = '0;
    if (!reset) begin
      if (bus.if_req_valid && (!bus.ls_req_valid || fetch_first_c)) begin
        grant_if_c = 1'b1;
      end else if (bus.ls_req_valid) begin
        grant_ls_c = 1'b1;
      end
    end
    if (grant_if_c) begin
      own_d       = OWN_IF;
      cmd_c.en    = 1'b1;
      cmd_c.we    = 1'b0;
      cmd_c.be    = '1;
      cmd_c.addr  = word_idx(bus.if_req_addr);
      cmd_c.wdata = bus.ls_req_wdata;
    end else if (grant_ls_c) begin
      own_d       = OWN_LS;
      store_d     = bus.ls_req_we;
      cmd_c.en    = 1'b1;
      cmd_c.we    = bus.ls_req_we;
      cmd_c.be    = bus.ls_req_be;
      cmd_c.addr  = word_idx(bus.ls_req_addr);
      cmd_c.wdata = bus.ls_req_wdata;
    end
  end

  assign bus.if_req_ready = grant_if_c;
  assign bus.ls_req_ready = grant_ls_c;

  assign bus.mem_en    = cmd_c.en;
  assign bus.mem_we    = cmd_c.we;
  assign bus.mem_be    = cmd_c.be;
  assign bus.mem_addr  = cmd_c.addr;
  assign bus.mem_wdata = cmd_c.wdata;

  // Responses are forced low while reset is held; stores acknowledge with zero data
  assign bus.if_rsp_valid = !reset && (own_q == OWN_IF);
  assign bus.ls_rsp_valid = !reset && (own_q == OWN_LS);
  assign bus.if_rsp_data  = bus.if_rsp_valid ? bus.mem_rdata : '0;
  assign bus.ls_rsp_data  = (bus.ls_rsp_valid && !store_q) ? bus.mem_rdata : '0;

endmodule
